// File: rtl/stopwatch_ctrl_pkg.sv
// Shared encodings and widths for the stopwatch control block.
package stopwatch_ctrl_pkg;

    // BCD count layout: mins / tens-of-seconds / seconds / tenths
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned MIN_W     = 4;
    localparam int unsigned TENS_W    = 3;
    localparam int unsigned SEC_W     = 4;
    localparam int unsigned TENTH_W   = 4;

    // 9:59.9 is the last displayable value
    localparam logic [CNT_W-1:0] MAX_COUNT_DEFAULT = 16'h9599;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } sw_state_e;

    // States in which the counter datapath is allowed to advance
    function automatic logic is_counting(input sw_state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, level debouncer, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0_q, sync1_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has been held for DEBOUNCE_CYCLES clocks
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync1_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = stable_d & ~stable_q;
    end

    // Synchronizer, debounce state and registered press pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync0_q  <= btn_i;
            sync1_q  <= sync0_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop and lap/reset buttons drive the counter
// datapath enable/clear and select what the display shows.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter logic [CNT_W-1:0] MAX_COUNT       = MAX_COUNT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_ss,
    input  logic             btn_lr,
    input  logic [CNT_W-1:0] cnt,
    output logic             go,
    output logic             clr,
    output logic [CNT_W-1:0] disp,
    output logic             lap_led,
    output logic [1:0]       state
);

    logic             ss_p, lr_p;
    logic             sat;
    sw_state_e        state_q, state_d;
    logic             clr_q, clr_d;
    logic [CNT_W-1:0] lap_q, lap_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk_i   (clk),
        .rst_i   (reset),
        .btn_i   (btn_ss),
        .press_o (ss_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
        .clk_i   (clk),
        .rst_i   (reset),
        .btn_i   (btn_lr),
        .press_o (lr_p)
    );

    assign sat = (cnt == MAX_COUNT);

    // State, clear pulse and frozen lap value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            clr_q   <= 1'b0;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            lap_q   <= lap_d;
        end
    end

    // Next state; start/stop beats lap/reset, saturation beats lap/reset
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        lap_d   = lap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ss_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ss_p || sat) begin
                    state_d = ST_STOP;
                end else if (lr_p) begin
                    state_d = ST_LAP;
                    lap_d   = cnt;
                end
            end
            ST_LAP: begin
                if (ss_p || sat) begin
                    state_d = ST_STOP;
                end else if (lr_p) begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (ss_p) begin
                    state_d = ST_RUN;
                end else if (lr_p) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        go      = is_counting(state_q) && !sat;
        clr     = clr_q;
        lap_led = (state_q == ST_LAP);
        disp    = (state_q == ST_LAP) ? lap_q : cnt;
        state   = 2'(state_q);
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a small expected-value scoreboard.
module tb_stopwatch_ctrl;

    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_ss, btn_lr;
    logic [15:0] cnt;
    logic        go, clr, lap_led;
    logic [15:0] disp;
    logic [1:0]  state;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   clr_n, lap_n;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .MAX_COUNT(16'h9599)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .cnt     (cnt),
        .go      (go),
        .clr     (clr),
        .disp    (disp),
        .lap_led (lap_led),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic exp_push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Hold the chosen buttons well past the debounce window, then release and settle
    task automatic press(input logic ss, input logic lr, output int c_n, output int l_n);
        c_n = 0;
        l_n = 0;
        btn_ss = ss;
        btn_lr = lr;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 8) begin
                btn_ss = 1'b0;
                btn_lr = 1'b0;
            end
            if (clr === 1'b1) c_n++;
            if (state === 2'd2) l_n++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        cnt    = 16'h0042;

        // Reset state
        exp_push("rst_state", 16'd0);
        exp_push("rst_go", 16'd0);
        exp_push("rst_clr", 16'd0);
        exp_push("rst_lap_led", 16'd0);
        exp_push("rst_disp", 16'h0042);
        repeat (3) @(negedge clk);
        check(16'(state));
        check(16'(go));
        check(16'(clr));
        check(16'(lap_led));
        check(disp);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Start: RUN within 8 clocks of a clean press
        exp_push("start_state", 16'd1);
        exp_push("start_go", 16'd1);
        btn_ss = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (state === 2'd1) break;
        end
        check(16'(state));
        check(16'(go));
        btn_ss = 1'b0;
        repeat (10) @(negedge clk);

        // Stop
        exp_push("stop_state", 16'd3);
        exp_push("stop_go", 16'd0);
        exp_push("stop_disp", 16'h0042);
        press(1'b1, 1'b0, clr_n, lap_n);
        check(16'(state));
        check(16'(go));
        check(disp);

        // Bounce shorter than the debounce window is ignored
        exp_push("bounce_state", 16'd3);
        for (int i = 0; i < 10; i++) begin
            btn_ss = ~btn_ss;
            repeat (2) @(negedge clk);
        end
        btn_ss = 1'b0;
        repeat (12) @(negedge clk);
        check(16'(state));

        // Resume, then lap capture
        exp_push("resume_state", 16'd1);
        press(1'b1, 1'b0, clr_n, lap_n);
        check(16'(state));
        cnt = 16'h0123;
        exp_push("lap_state", 16'd2);
        exp_push("lap_disp", 16'h0123);
        exp_push("lap_led_on", 16'd1);
        press(1'b0, 1'b1, clr_n, lap_n);
        check(16'(state));
        check(disp);
        check(16'(lap_led));
        cnt = 16'h0130;
        exp_push("lap_frozen_disp", 16'h0123);
        exp_push("lap_go", 16'd1);
        @(negedge clk);
        check(disp);
        check(16'(go));

        // Lap release
        exp_push("unlap_state", 16'd1);
        exp_push("unlap_disp", 16'h0130);
        exp_push("unlap_led", 16'd0);
        press(1'b0, 1'b1, clr_n, lap_n);
        check(16'(state));
        check(disp);
        check(16'(lap_led));
        cnt = 16'h0131;
        exp_push("unlap_track", 16'h0131);
        @(negedge clk);
        check(disp);

        // Stop, then reset to IDLE with a single clear pulse
        press(1'b1, 1'b0, clr_n, lap_n);
        exp_push("clr_state", 16'd0);
        exp_push("clr_pulses", 16'd1);
        press(1'b0, 1'b1, clr_n, lap_n);
        check(16'(state));
        check(16'(clr_n));

        // lap/reset in IDLE does nothing
        exp_push("idle_lr_state", 16'd0);
        exp_push("idle_lr_clr", 16'd0);
        press(1'b0, 1'b1, clr_n, lap_n);
        check(16'(state));
        check(16'(clr_n));

        // Saturation: go drops at once, STOP on the next edge
        cnt = 16'h0200;
        press(1'b1, 1'b0, clr_n, lap_n);
        exp_push("sat_run", 16'd1);
        exp_push("sat_go", 16'd0);
        exp_push("sat_state", 16'd3);
        check(16'(state));
        cnt = 16'h9599;
        #1;
        check(16'(go));
        @(negedge clk);
        check(16'(state));

        // Simultaneous presses: start/stop wins, no lap entry
        cnt = 16'h0300;
        press(1'b1, 1'b0, clr_n, lap_n);
        exp_push("both_state", 16'd3);
        exp_push("both_lap_cycles", 16'd0);
        exp_push("both_lap_led", 16'd0);
        press(1'b1, 1'b1, clr_n, lap_n);
        check(16'(state));
        check(16'(lap_n));
        check(16'(lap_led));

        // Asynchronous reset while in LAP
        press(1'b1, 1'b0, clr_n, lap_n);
        cnt = 16'h0305;
        exp_push("pre_rst_lap", 16'd2);
        press(1'b0, 1'b1, clr_n, lap_n);
        check(16'(state));
        exp_push("arst_state", 16'd0);
        exp_push("arst_lap_led", 16'd0);
        exp_push("arst_go", 16'd0);
        exp_push("arst_clr", 16'd0);
        exp_push("arst_disp", 16'h0306);
        cnt = 16'h0306;
        #2;
        reset = 1'b1;
        #1;
        check(16'(state));
        check(16'(lap_led));
        check(16'(go));
        check(16'(clr));
        check(disp);
        @(negedge clk);
        reset = 1'b0;
        clr_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (clr === 1'b1) clr_n++;
        end
        exp_push("post_rst_clr", 16'd0);
        exp_push("post_rst_state", 16'd0);
        check(16'(clr_n));
        check(16'(state));

        exp_push("sb_drained", 16'd0);
        check(16'(sb.size() - 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
